// File: rtl/consumer_sftm_pkg.sv
// Shared definitions for the SFTM descriptor stream: field layout, first gid
// and FSM state encodings, common to the producer and the consumer.
package consumer_sftm_pkg;

    // Descriptor field slots, each slot is WIDTH bits wide except the gid,
    // which sits above the four WIDTH-wide slots:
    // {gid, row_group_idx, col_tile_idx, col_start, col_end}
    localparam int FLD_COL_END   = 0;
    localparam int FLD_COL_START = 1;
    localparam int FLD_COL_TILE  = 2;
    localparam int FLD_ROW_GROUP = 3;
    localparam int FLD_GID       = 4;

    // The producer numbers tile groups starting from 1.
    localparam int FIRST_GID = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Packed descriptor width: gid plus four WIDTH-wide fields.
    function automatic int desc_width(input int width, input int gid_width);
        return gid_width + 4 * width;
    endfunction

endpackage

// File: rtl/consumer_sftm_desc_fifo.sv
// Synchronous descriptor FIFO. A push while full is accepted when a pop
// happens in the same cycle; the head is presented combinationally.
module sftm_desc_fifo #(
    parameter int DEPTH  = 8,
    parameter int DESC_W = 80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DESC_W-1:0]          wr_data,
    output logic [DESC_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              push_en;
    logic              pop_en;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Storage array; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy, flushed by reset or a synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(push_en) - LW'(pop_en);
        end
    end

endmodule

// File: rtl/consumer_sftm.sv
// Timing-model consumer for the SFTM tile-group descriptor stream: buffers
// descriptors, services each for a span-dependent time, reports completions
// and gathers rate statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in service; pops the FIFO head when one is present
// ST_SERVE | counting down the service timer of the latched descriptor
module consumer_sftm
    import consumer_sftm_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int GID_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int SERVICE_BASE = 16,
    parameter int COL_SHIFT    = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              groups_total,
    input  logic                          tile_valid,
    input  logic [GID_WIDTH-1:0]          gid,
    input  logic [WIDTH-1:0]              row_group_idx,
    input  logic [WIDTH-1:0]              col_tile_idx,
    input  logic [WIDTH-1:0]              col_start,
    input  logic [WIDTH-1:0]              col_end,
    output logic                          done_valid,
    output logic [GID_WIDTH-1:0]          done_gid,
    output logic [WIDTH-1:0]              done_row_group_idx,
    output logic [WIDTH-1:0]              done_col_tile_idx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [$clog2(FIFO_DEPTH):0]   max_level,
    output logic [CNT_WIDTH-1:0]          completed,
    output logic [CNT_WIDTH-1:0]          drop_count,
    output logic [CNT_WIDTH-1:0]          stall_cycles,
    output logic                          overflow,
    output logic                          seq_error,
    output logic                          range_error,
    output logic                          all_done
);

    localparam int DESC_W = desc_width(WIDTH, GID_WIDTH);
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;

    state_t                 state;
    logic [31:0]            timer;
    logic                   started;
    logic [GID_WIDTH-1:0]   expected_gid;

    logic [DESC_W-1:0]      push_data;
    logic [DESC_W-1:0]      head;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic                   fire;
    logic                   done_now;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    logic [GID_WIDTH-1:0]   head_gid;
    logic [WIDTH-1:0]       head_row;
    logic [WIDTH-1:0]       head_tile;
    logic [WIDTH-1:0]       head_cs;
    logic [WIDTH-1:0]       head_ce;
    logic                   head_reversed;
    logic [WIDTH:0]         span;
    logic [31:0]            svc_raw;
    logic [31:0]            svc_m1;

    logic [CNT_WIDTH-1:0]   completed_nxt;
    logic [CNT_WIDTH-1:0]   drop_nxt;
    logic [CNT_WIDTH-1:0]   stall_nxt;
    logic [CNT_WIDTH:0]     done_sum;
    logic                   done_hit;
    logic [LW-1:0]          level_nxt;

    assign push_data = {gid, row_group_idx, col_tile_idx, col_start, col_end};

    assign head_gid  = head[FLD_GID*WIDTH +: GID_WIDTH];
    assign head_row  = head[FLD_ROW_GROUP*WIDTH +: WIDTH];
    assign head_tile = head[FLD_COL_TILE*WIDTH +: WIDTH];
    assign head_cs   = head[FLD_COL_START*WIDTH +: WIDTH];
    assign head_ce   = head[FLD_COL_END*WIDTH +: WIDTH];

    // A start cycle discards both the incoming descriptor and any pop.
    assign fire     = tile_valid && !start;
    assign done_now = (state == ST_SERVE) && (timer == '0);
    assign pop      = !start && !fifo_empty && ((state == ST_IDLE) || done_now);
    assign push_ok  = fire && (!fifo_full || pop);
    assign drop     = fire && fifo_full && !pop;

    assign done_valid = done_now;
    assign busy       = (state == ST_SERVE);

    sftm_desc_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DESC_W (DESC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start),
        .push    (push_ok),
        .pop     (pop),
        .wr_data (push_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Service time of the FIFO head; a reversed column range costs the base only.
    always_comb begin
        head_reversed = (head_ce < head_cs);
        span          = '0;
        if (!head_reversed) begin
            span = {1'b0, head_ce} - {1'b0, head_cs} + 1'b1;
        end
        svc_raw = 32'(SERVICE_BASE) + 32'(span >> COL_SHIFT);
        svc_m1  = (svc_raw == '0) ? '0 : svc_raw - 1'b1;
    end

    // Next statistic values; all_done compares against these so it rises on
    // the same edge that the final completion or drop is counted.
    always_comb begin
        completed_nxt = completed;
        drop_nxt      = drop_count;
        stall_nxt     = stall_cycles;
        if (done_now && !(&completed)) completed_nxt = completed + 1'b1;
        if (drop && !(&drop_count))    drop_nxt      = drop_count + 1'b1;
        if ((state == ST_IDLE) && fifo_empty && started && !all_done && !(&stall_cycles)) begin
            stall_nxt = stall_cycles + 1'b1;
        end
        done_sum  = {1'b0, completed_nxt} + {1'b0, drop_nxt};
        done_hit  = (groups_total != '0) && (done_sum == (CNT_WIDTH+1)'(groups_total));
        level_nxt = fifo_level + LW'(push_ok) - LW'(pop);
    end

    // Service FSM: pop, latch and time each descriptor; back-to-back pops
    // happen in the completion cycle so there is no bubble between tiles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            timer              <= '0;
            done_gid           <= '0;
            done_row_group_idx <= '0;
            done_col_tile_idx  <= '0;
        end else if (start) begin
            state              <= ST_IDLE;
            timer              <= '0;
            done_gid           <= '0;
            done_row_group_idx <= '0;
            done_col_tile_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        done_gid           <= head_gid;
                        done_row_group_idx <= head_row;
                        done_col_tile_idx  <= head_tile;
                        timer              <= svc_m1;
                        state              <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (pop) begin
                        done_gid           <= head_gid;
                        done_row_group_idx <= head_row;
                        done_col_tile_idx  <= head_tile;
                        timer              <= svc_m1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Statistics, sticky error flags and gid tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            completed    <= '0;
            drop_count   <= '0;
            stall_cycles <= '0;
            max_level    <= '0;
            overflow     <= 1'b0;
            seq_error    <= 1'b0;
            range_error  <= 1'b0;
            all_done     <= 1'b0;
            started      <= 1'b0;
            expected_gid <= GID_WIDTH'(FIRST_GID);
        end else if (start) begin
            completed    <= '0;
            drop_count   <= '0;
            stall_cycles <= '0;
            max_level    <= '0;
            overflow     <= 1'b0;
            seq_error    <= 1'b0;
            range_error  <= 1'b0;
            all_done     <= 1'b0;
            started      <= 1'b1;
            expected_gid <= GID_WIDTH'(FIRST_GID);
        end else begin
            completed    <= completed_nxt;
            drop_count   <= drop_nxt;
            stall_cycles <= stall_nxt;
            if (level_nxt > max_level) max_level <= level_nxt;
            if (drop) overflow <= 1'b1;
            if (fire) begin
                if (gid != expected_gid) seq_error <= 1'b1;
                expected_gid <= gid + 1'b1;
            end
            if (pop && head_reversed) range_error <= 1'b1;
            if (done_hit) all_done <= 1'b1;
        end
    end

endmodule
